// File: rtl/falafel_mem_mux.sv
// falafel_mem_mux: round-robin shared memory port with in-order response routing
package falafel_pkg;
    localparam int DATA_W = 32;
endpackage

module falafel_mem_mux #(
    parameter int NUM_PORTS = 4,
    parameter int MAX_OUTST = 8,
    parameter int DATA_W    = falafel_pkg::DATA_W
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NUM_PORTS-1:0]             cli_req_val_i,
    output logic [NUM_PORTS-1:0]             cli_req_rdy_o,
    input  logic [NUM_PORTS-1:0]             cli_req_is_write_i,
    input  logic [NUM_PORTS-1:0]             cli_req_is_cas_i,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0] cli_req_addr_i,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0] cli_req_data_i,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0] cli_req_cas_exp_i,
    output logic [NUM_PORTS-1:0]             cli_resp_val_o,
    input  logic [NUM_PORTS-1:0]             cli_resp_rdy_i,
    output logic [NUM_PORTS-1:0][DATA_W-1:0] cli_resp_data_o,
    output logic                             mem_req_val_o,
    input  logic                             mem_req_rdy_i,
    output logic                             mem_req_is_write_o,
    output logic                             mem_req_is_cas_o,
    output logic [DATA_W-1:0]                mem_req_addr_o,
    output logic [DATA_W-1:0]                mem_req_data_o,
    output logic [DATA_W-1:0]                mem_req_cas_exp_o,
    input  logic                             mem_resp_val_i,
    output logic                             mem_resp_rdy_o,
    input  logic [DATA_W-1:0]                mem_resp_data_i,
    output logic [$clog2(MAX_OUTST):0]       outst_cnt_o,
    output logic                             spurious_o
);
    localparam int ID_W  = $clog2(NUM_PORTS);
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

    logic [ID_W-1:0]  rr_q, rr_d, lock_id_q, lock_id_d, win_id, head;
    logic             lock_q, lock_d, win_val, full, empty, push, pop, spurious_q, spurious_d;
    logic [ID_W:0]    j;
    logic [ID_W-1:0]  fifo_q [MAX_OUTST];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Scan downwards so the first valid port at or after rr_q is the last one written
    always_comb begin
        win_val = 1'b0;
        win_id = '0;
        j = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            j = {1'b0, rr_q} + (ID_W+1)'(k);
            j = (j >= (ID_W+1)'(NUM_PORTS)) ? j - (ID_W+1)'(NUM_PORTS) : j;
            if (cli_req_val_i[j[ID_W-1:0]]) begin
                win_val = 1'b1;
                win_id = j[ID_W-1:0];
            end
        end
        if (lock_q && cli_req_val_i[lock_id_q]) begin
            win_val = 1'b1;
            win_id = lock_id_q;
        end
    end

    assign full               = cnt_q == CNT_W'(MAX_OUTST);
    assign empty              = cnt_q == '0;
    assign mem_req_val_o      = win_val && !full;
    assign push               = mem_req_val_o && mem_req_rdy_i;
    assign cli_req_rdy_o      = push ? ONE << win_id : '0;
    assign mem_req_is_write_o = cli_req_is_write_i[win_id];
    assign mem_req_is_cas_o   = cli_req_is_cas_i[win_id];
    assign mem_req_addr_o     = cli_req_addr_i[win_id];
    assign mem_req_data_o     = cli_req_data_i[win_id];
    assign mem_req_cas_exp_o  = cli_req_cas_exp_i[win_id];
    assign head               = fifo_q[rd_q];
    assign mem_resp_rdy_o     = !empty && cli_resp_rdy_i[head];
    assign pop                = mem_resp_val_i && mem_resp_rdy_o;
    assign cli_resp_val_o     = (mem_resp_val_i && !empty) ? ONE << head : '0;
    assign cli_resp_data_o    = {NUM_PORTS{mem_resp_data_i}};
    assign outst_cnt_o        = cnt_q;
    assign spurious_o         = spurious_q;

    always_comb begin
        rr_d       = push ? ((win_id == ID_W'(NUM_PORTS - 1)) ? '0 : win_id + 1'b1) : rr_q;
        lock_d     = push ? 1'b0 : (mem_req_val_o ? 1'b1 : lock_q);
        lock_id_d  = (mem_req_val_o && !push) ? win_id : lock_id_q;
        cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
        spurious_d = spurious_q || (mem_resp_val_i && empty);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_id_q  <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            spurious_q <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
            wr_q       <= wr_q + PTR_W'(push);
            rd_q       <= rd_q + PTR_W'(pop);
            cnt_q      <= cnt_d;
            spurious_q <= spurious_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && push) fifo_q[wr_q] <= win_id;
    end
endmodule
